// File: rtl/pixel_histogram_pkg.sv
// rtl/pixel_histogram_pkg.sv - shared state encoding and sizing constants for the pixel histogram.
package pixel_histogram_pkg;

    localparam int BIN_BITS_DEF = 10;
    localparam int NUM_BINS     = 1 << BIN_BITS_DEF;
    localparam int FRAME_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DUMP
    } state_e;

endpackage

// File: rtl/pixel_histogram_hist_ram.sv
// rtl/pixel_histogram_hist_ram.sv - simple dual-port bin RAM, synchronous read-first.
module pixel_histogram_hist_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // A read of the address being written returns the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_histogram.sv
// rtl/pixel_histogram.sv - per-frame intensity histogram with clear, accumulate and dump phases.
// HIST_SAT_EN: when defined, bin counters saturate instead of wrapping.
module pixel_histogram #(
    parameter int PIX_WIDTH = 10,
    parameter int BIN_BITS  = 10,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk_pixel_i,
    input  logic                 reset_i,
    input  logic [PIX_WIDTH-1:0] pd_i,
    input  logic                 fv_i,
    input  logic                 lv_i,
    output logic [CNT_WIDTH-1:0] hist_data_o,
    output logic [BIN_BITS-1:0]  hist_bin_o,
    output logic                 hist_valid_o,
    output logic                 hist_last_o,
    input  logic                 hist_ready_i,
    output logic                 busy_o,
    output logic                 frame_drop_o,
    output logic [15:0]          frame_cnt_o
);

    import pixel_histogram_pkg::*;

    state_e                 state_q, state_d;
    logic                   fv_q, fv_d;
    logic [BIN_BITS-1:0]    clr_addr_q, clr_addr_d;
    logic                   drain_cnt_q, drain_cnt_d;
    logic                   s1_vld_q, s1_vld_d;
    logic [BIN_BITS-1:0]    s1_bin_q, s1_bin_d;
    logic                   s2_vld_q, s2_vld_d;
    logic [BIN_BITS-1:0]    s2_bin_q, s2_bin_d;
    logic [CNT_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic                   s3_vld_q, s3_vld_d;
    logic [BIN_BITS-1:0]    s3_bin_q, s3_bin_d;
    logic [CNT_WIDTH-1:0]   s3_data_q, s3_data_d;
    logic [BIN_BITS:0]      rd_addr_q, rd_addr_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [BIN_BITS-1:0]    pend_bin_q, pend_bin_d;
    logic                   out_vld_q, out_vld_d;
    logic [BIN_BITS-1:0]    out_bin_q, out_bin_d;
    logic [CNT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   buf_vld_q, buf_vld_d;
    logic [BIN_BITS-1:0]    buf_bin_q, buf_bin_d;
    logic [CNT_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic                   busy_q, busy_d;
    logic                   frame_drop_q, frame_drop_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic                   fv_rise, fv_fall, s0_vld, pop, issue;
    logic [BIN_BITS-1:0]    pix_bin;
    logic [CNT_WIDTH-1:0]   base, ram_rdata, ram_wdata;
    logic [1:0]             occ;
    logic                   ram_we;
    logic [BIN_BITS-1:0]    ram_waddr, ram_raddr;

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
`ifdef HIST_SAT_EN
        bump = (&v) ? v : v + CNT_WIDTH'(1);
`else
        bump = v + CNT_WIDTH'(1);
`endif
    endfunction

    always_comb begin
        fv_d         = fv_i;
        fv_rise      = fv_i & ~fv_q;
        fv_fall      = ~fv_i & fv_q;
        pix_bin      = pd_i[PIX_WIDTH-1 -: BIN_BITS];
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        drain_cnt_d  = drain_cnt_q;
        rd_addr_d    = rd_addr_q;
        frame_cnt_d  = frame_cnt_q;
        busy_d       = (state_q == ST_CLEAR) || (state_q == ST_DUMP);
        frame_drop_d = fv_rise && ((state_q == ST_CLEAR) || (state_q == ST_DRAIN) || (state_q == ST_DUMP));

        // Read-modify-write: the two newest writes may not be visible in the RAM read yet.
        s0_vld   = fv_i & lv_i & ((state_q == ST_ACCUM) | ((state_q == ST_IDLE) & fv_rise));
        s1_vld_d = s0_vld;
        s1_bin_d = pix_bin;
        if (s2_vld_q && (s2_bin_q == s1_bin_q)) begin
            base = s2_data_q;
        end else if (s3_vld_q && (s3_bin_q == s1_bin_q)) begin
            base = s3_data_q;
        end else begin
            base = ram_rdata;
        end
        s2_vld_d  = s1_vld_q;
        s2_bin_d  = s1_bin_q;
        s2_data_d = bump(base);
        s3_vld_d  = s2_vld_q;
        s3_bin_d  = s2_bin_q;
        s3_data_d = s2_data_q;

        // Dump: at most two words held between read-in-flight, buffer and output register.
        pop        = out_vld_q & hist_ready_i;
        occ        = 2'(out_vld_q) + 2'(buf_vld_q) + 2'(pend_vld_q);
        issue      = (state_q == ST_DUMP) && !rd_addr_q[BIN_BITS] && ((occ - 2'(pop)) < 2'd2);
        pend_vld_d = issue;
        pend_bin_d = rd_addr_q[BIN_BITS-1:0];
        if (issue) begin
            rd_addr_d = rd_addr_q + (BIN_BITS+1)'(1);
        end

        out_vld_d  = out_vld_q;
        out_bin_d  = out_bin_q;
        out_data_d = out_data_q;
        buf_vld_d  = buf_vld_q;
        buf_bin_d  = buf_bin_q;
        buf_data_d = buf_data_q;
        if (!out_vld_q || pop) begin
            if (buf_vld_q) begin
                out_vld_d  = 1'b1;
                out_bin_d  = buf_bin_q;
                out_data_d = buf_data_q;
                buf_vld_d  = pend_vld_q;
                buf_bin_d  = pend_bin_q;
                buf_data_d = ram_rdata;
            end else begin
                out_vld_d  = pend_vld_q;
                out_bin_d  = pend_bin_q;
                out_data_d = ram_rdata;
            end
        end else if (pend_vld_q) begin
            buf_vld_d  = 1'b1;
            buf_bin_d  = pend_bin_q;
            buf_data_d = ram_rdata;
        end
        out_last_d = out_vld_d & (&out_bin_d);

        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + BIN_BITS'(1);
                if (&clr_addr_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (fv_rise) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (fv_fall) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = 1'b1;
                rd_addr_d   = '0;
                if (drain_cnt_q) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (pop && out_last_q) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        ram_raddr = (state_q == ST_DUMP) ? rd_addr_q[BIN_BITS-1:0] : pix_bin;
        ram_we    = s2_vld_q;
        ram_waddr = s2_bin_q;
        ram_wdata = s2_data_q;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end else if (state_q == ST_DUMP) begin
            ram_we    = issue;
            ram_waddr = rd_addr_q[BIN_BITS-1:0];
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk_pixel_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_CLEAR;
            fv_q         <= 1'b0;
            clr_addr_q   <= '0;
            drain_cnt_q  <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_bin_q     <= '0;
            s2_vld_q     <= 1'b0;
            s2_bin_q     <= '0;
            s2_data_q    <= '0;
            s3_vld_q     <= 1'b0;
            s3_bin_q     <= '0;
            s3_data_q    <= '0;
            rd_addr_q    <= '0;
            pend_vld_q   <= 1'b0;
            pend_bin_q   <= '0;
            out_vld_q    <= 1'b0;
            out_bin_q    <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            buf_vld_q    <= 1'b0;
            buf_bin_q    <= '0;
            buf_data_q   <= '0;
            busy_q       <= 1'b0;
            frame_drop_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fv_q         <= fv_d;
            clr_addr_q   <= clr_addr_d;
            drain_cnt_q  <= drain_cnt_d;
            s1_vld_q     <= s1_vld_d;
            s1_bin_q     <= s1_bin_d;
            s2_vld_q     <= s2_vld_d;
            s2_bin_q     <= s2_bin_d;
            s2_data_q    <= s2_data_d;
            s3_vld_q     <= s3_vld_d;
            s3_bin_q     <= s3_bin_d;
            s3_data_q    <= s3_data_d;
            rd_addr_q    <= rd_addr_d;
            pend_vld_q   <= pend_vld_d;
            pend_bin_q   <= pend_bin_d;
            out_vld_q    <= out_vld_d;
            out_bin_q    <= out_bin_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            buf_vld_q    <= buf_vld_d;
            buf_bin_q    <= buf_bin_d;
            buf_data_q   <= buf_data_d;
            busy_q       <= busy_d;
            frame_drop_q <= frame_drop_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    pixel_histogram_hist_ram #(
        .ADDR_W (BIN_BITS),
        .DATA_W (CNT_WIDTH)
    ) u_hist_ram (
        .clk_i   (clk_pixel_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign hist_data_o  = out_data_q;
    assign hist_bin_o   = out_bin_q;
    assign hist_valid_o = out_vld_q;
    assign hist_last_o  = out_last_q;
    assign busy_o       = busy_q;
    assign frame_drop_o = frame_drop_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_pixel_histogram.sv
// tb/tb_pixel_histogram.sv - scoreboard bench for pixel_histogram at default and 4-bit counter widths.
module tb_pixel_histogram;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pd;
    logic        fv, lv, hist_ready;
    logic [23:0] hist_data;
    logic [9:0]  hist_bin, s_bin;
    logic        hist_valid, hist_last, busy, frame_drop;
    logic [15:0] frame_cnt, s_frame_cnt;
    logic [3:0]  s_data;
    logic        s_valid, s_last, s_busy, s_drop;

    always #5 clk = ~clk;

    pixel_histogram dut (
        .clk_pixel_i (clk), .reset_i (rst), .pd_i (pd), .fv_i (fv), .lv_i (lv),
        .hist_data_o (hist_data), .hist_bin_o (hist_bin), .hist_valid_o (hist_valid),
        .hist_last_o (hist_last), .hist_ready_i (hist_ready), .busy_o (busy),
        .frame_drop_o (frame_drop), .frame_cnt_o (frame_cnt)
    );

    pixel_histogram #(.CNT_WIDTH(4)) dut_s (
        .clk_pixel_i (clk), .reset_i (rst), .pd_i (pd), .fv_i (fv), .lv_i (lv),
        .hist_data_o (s_data), .hist_bin_o (s_bin), .hist_valid_o (s_valid),
        .hist_last_o (s_last), .hist_ready_i (hist_ready), .busy_o (s_busy),
        .frame_drop_o (s_drop), .frame_cnt_o (s_frame_cnt)
    );

    typedef struct { int bin; int data; bit last; } exp_t;
    exp_t       sb[$];
    exp_t       sb_s[$];
    exp_t       e, es;
    logic [9:0] pix[$];
    int         errors = 0;
    int         checks = 0;
    int         drop_cnt = 0;
    int         drop_cnt_s = 0;
    bit         rand_rdy = 1'b0;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (frame_drop) drop_cnt++;
        if (s_drop) drop_cnt_s++;
        if (!rst && hist_valid && hist_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", longint'(hist_bin), -1);
            end else begin
                e = sb.pop_front();
                check($sformatf("word_bin%0d", e.bin), longint'({hist_bin, hist_data, hist_last}),
                      longint'({e.bin[9:0], e.data[23:0], e.last}));
            end
        end
        if (!rst && s_valid && hist_ready) begin
            if (sb_s.size() == 0) begin
                check("unexpected_word_small", longint'(s_bin), -1);
            end else begin
                es = sb_s.pop_front();
                check($sformatf("small_word_bin%0d", es.bin), longint'({s_bin, s_data, s_last}),
                      longint'({es.bin[9:0], es.data[3:0], es.last}));
            end
        end
    end

    initial begin
        hist_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            hist_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int v, input int n);
        for (int i = 0; i < n; i++) pix.push_back(10'(v));
    endtask

    task automatic push_expected();
        int cnt[1024];
        exp_t x;
        for (int b = 0; b < 1024; b++) cnt[b] = 0;
        foreach (pix[i]) cnt[pix[i]]++;
        for (int b = 0; b < 1024; b++) begin
            x.bin  = b;
            x.last = (b == 1023);
            x.data = cnt[b] % (1 << 24);
            sb.push_back(x);
`ifdef HIST_SAT_EN
            x.data = (cnt[b] > 15) ? 15 : cnt[b];
`else
            x.data = cnt[b] % 16;
`endif
            sb_s.push_back(x);
        end
    endtask

    task automatic play_frame(input int ppl, input bit expect_it);
        fv = 1'b1;
        tick();
        tick();
        foreach (pix[i]) begin
            if (i != 0 && (i % ppl) == 0) begin
                lv = 1'b0;
                tick();
                tick();
            end
            lv = 1'b1;
            pd = pix[i];
            tick();
        end
        lv = 1'b0;
        tick();
        tick();
        fv = 1'b0;
        tick();
        if (expect_it) push_expected();
        pix.delete();
    endtask

    task automatic wait_drain(input int exp_frames);
        int n = 0;
        while ((sb.size() != 0 || sb_s.size() != 0) && n < 8000) begin
            tick();
            n++;
        end
        check("drain_in_time", longint'(n < 8000), 1);
        tick();
        tick();
        check("frame_cnt", frame_cnt, exp_frames);
        check("busy_after_dump", busy, 0);
        check("valid_after_dump", hist_valid, 0);
    endtask

    initial begin
        int busy_n = 0;
        int d0, ds0, n;
        rst = 1'b1;
        fv  = 1'b0;
        lv  = 1'b0;
        pd  = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", hist_valid, 0);
        check("rst_last", hist_last, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", frame_drop, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_data", hist_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
        end
        check("clear_busy_cycles", busy_n, 1024);
        check("busy_low_idle", busy, 0);
        tick();

        add(0, 1);
        play_frame(1, 1'b1);
        wait_drain(1);

        add(10'h155, 16);
        play_frame(8, 1'b1);
        wait_drain(2);

        add(5, 2); add(7, 1); add(5, 1); add(7, 2);
        play_frame(6, 1'b1);
        wait_drain(3);

        rand_rdy = 1'b1;
        add(10'h155, 16);
        play_frame(8, 1'b1);
        wait_drain(4);
        add(10'h155, 16);
        play_frame(8, 1'b1);
        wait_drain(5);
        rand_rdy = 1'b0;
        tick();

        add(100, 1); add(200, 1); add(100, 1);
        play_frame(3, 1'b1);
        n = 0;
        while (!hist_valid && n < 50) begin
            tick();
            n++;
        end
        check("dump_started", longint'(hist_valid), 1);
        d0  = drop_cnt;
        ds0 = drop_cnt_s;
        add(50, 9);
        play_frame(3, 1'b0);
        wait_drain(6);
        check("drop_pulses", drop_cnt - d0, 1);
        check("drop_pulses_small", drop_cnt_s - ds0, 1);

        add(1023, 2); add(0, 1); add(512, 1);
        play_frame(2, 1'b1);
        wait_drain(7);

        add(3, 20);
        play_frame(10, 1'b1);
        wait_drain(8);
        check("frame_cnt_small", s_frame_cnt, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
